// File: rtl/pattern_gen.sv
// pattern_gen: video test-pattern generator with bars, checkerboard
// and a bouncing box, colour aligned to timing through a 2-stage pipe.
module pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32
) (
  input  logic        rfr_clk,
  input  logic        reset_n,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [11:0] h_count,
  input  logic [11:0] v_count,
  input  logic        video_on_in,
  input  logic [1:0]  mode,
  input  logic [3:0]  step,
  output logic        h_sync,
  output logic        v_sync,
  output logic        video_on,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [15:0] frame_count
);

  localparam logic [12:0] XMAX   = 13'(H_ACTIVE - BOX_SIZE);
  localparam logic [12:0] YMAX   = 13'(V_ACTIVE - BOX_SIZE);
  localparam logic [12:0] BOX    = 13'(BOX_SIZE);
  localparam logic [11:0] BAR_W  = 12'(H_ACTIVE / 8);
  localparam logic [11:0] V_TICK = 12'(V_ACTIVE);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        von;
    logic [11:0] rgb;
  } pix_t;

  pix_t        st1_d, st1_q, st2_q;
  logic [1:0]  mode_q;
  logic [3:0]  step_q;
  logic [15:0] frame_q;
  logic [11:0] box_x_q, box_y_q;
  logic        dir_x_q, dir_y_q;
  logic [12:0] x_d, y_d;
  logic        tick;
  logic [11:0] bar_idx;
  logic [11:0] bar_rgb;
  logic        in_box;

  // One axis of box motion; result is {dir, pos}. Sums are
  // 13 bits wide so a position near the edge cannot carry out.
  function automatic logic [12:0] axis_next(
    input logic [11:0] pos,
    input logic        dir,
    input logic [3:0]  stp,
    input logic [12:0] lim
  );
    logic [12:0] sum;
    sum = {1'b0, pos} + {9'd0, stp};
    if (stp == 4'd0)
      return {dir, pos};
    if (dir) begin
      if (sum >= lim)
        return {1'b0, lim[11:0]};
      return {1'b1, sum[11:0]};
    end
    if ({1'b0, pos} <= {9'd0, stp})
      return {1'b1, 12'd0};
    return {1'b0, pos - {8'd0, stp}};
  endfunction

  assign tick = (v_count == V_TICK) && (h_count == 12'd0);

  assign x_d = axis_next(box_x_q, dir_x_q, step_q, XMAX);
  assign y_d = axis_next(box_y_q, dir_y_q, step_q, YMAX);

  assign bar_idx = h_count / BAR_W;

  assign in_box =
    ({1'b0, h_count} >= {1'b0, box_x_q}) &&
    ({1'b0, h_count} <  ({1'b0, box_x_q} + BOX)) &&
    ({1'b0, v_count} >= {1'b0, box_y_q}) &&
    ({1'b0, v_count} <  ({1'b0, box_y_q} + BOX));

  // Bar colour lookup; anything right of bar 7 is black.
  always_comb begin
    bar_rgb = 12'h000;
    case (bar_idx)
      12'd0:   bar_rgb = 12'hFFF;
      12'd1:   bar_rgb = 12'hFF0;
      12'd2:   bar_rgb = 12'h0FF;
      12'd3:   bar_rgb = 12'h0F0;
      12'd4:   bar_rgb = 12'hF0F;
      12'd5:   bar_rgb = 12'hF00;
      12'd6:   bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end

  // Stage-1 colour decision from the current pixel inputs.
  always_comb begin
    st1_d.hs  = h_sync_in;
    st1_d.vs  = v_sync_in;
    st1_d.von = video_on_in;
    st1_d.rgb = bar_rgb;
    unique case (1'b1)
      (mode_q == 2'd0): st1_d.rgb = bar_rgb;
      (mode_q == 2'd1):
        st1_d.rgb = (h_count[5] ^ v_count[5]) ? 12'hFFF : 12'h000;
      (mode_q == 2'd2):
        st1_d.rgb = in_box ? 12'hF00 : 12'h00F;
      (mode_q == 2'd3):
        st1_d.rgb = in_box ? 12'hF00 : bar_rgb;
      default: st1_d.rgb = bar_rgb;
    endcase
  end

  // Two-stage pixel pipeline keeps timing aligned with colour.
  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      st1_q <= '0;
      st2_q <= '0;
    end else begin
      st1_q <= st1_d;
      st2_q <= st1_q;
    end
  end

  // Per-frame state: controls, frame counter and box motion.
  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= 2'd0;
      step_q  <= 4'd0;
      frame_q <= 16'd0;
      box_x_q <= 12'd0;
      box_y_q <= 12'd0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else if (tick) begin
      mode_q  <= mode;
      step_q  <= step;
      frame_q <= frame_q + 16'd1;
      box_x_q <= x_d[11:0];
      dir_x_q <= x_d[12];
      box_y_q <= y_d[11:0];
      dir_y_q <= y_d[12];
    end
  end

  assign h_sync      = st2_q.hs;
  assign v_sync      = st2_q.vs;
  assign video_on    = st2_q.von;
  assign red         = st2_q.von ? st2_q.rgb[11:8] : 4'h0;
  assign green       = st2_q.von ? st2_q.rgb[7:4]  : 4'h0;
  assign blue        = st2_q.von ? st2_q.rgb[3:0]  : 4'h0;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: scoreboard bench for pattern_gen; a frame-level
// model predicts colour, timing and frame count for each pixel.
module tb_pattern_gen;

  localparam int H = 640;
  localparam int V = 480;
  localparam int B = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs_i = 1'b0, vs_i = 1'b0, von_i = 1'b0;
  logic [11:0] hc_i = '0, vc_i = '0;
  logic [1:0]  mode_r = '0;
  logic [3:0]  step_r = '0;
  logic        h_sync, v_sync, video_on;
  logic [3:0]  red, green, blue;
  logic [15:0] frame_count;

  pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(B)) dut (
    .rfr_clk(clk), .reset_n(rst_n),
    .h_sync_in(hs_i), .v_sync_in(vs_i),
    .h_count(hc_i), .v_count(vc_i),
    .video_on_in(von_i), .mode(mode_r), .step(step_r),
    .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on),
    .red(red), .green(green), .blue(blue),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] val;
  } ent_t;

  ent_t pq[$];
  ent_t fq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // frame-level model state
  int m_mode, m_step, bx, by, m_dx, m_dy, m_fc;
  int nxt_mode = 0, nxt_step = 0;

  task automatic model_reset();
    m_mode = 0; m_step = 0; bx = 0; by = 0;
    m_dx = 1; m_dy = 1; m_fc = 0;
  endtask

  task automatic move(inout int p, inout int d,
                      input int s, input int mx);
    if (s == 0) return;
    if (d == 1) begin
      if (p + s >= mx) begin p = mx; d = 0; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1; end
      else p = p - s;
    end
  endtask

  function automatic logic [11:0] bar(int h);
    int i;
    i = h / (H / 8);
    if (i > 7) i = 7;
    case (i)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] exp_col(int h, int v);
    bit inb;
    inb = (h >= bx) && (h < bx + B) && (v >= by) && (v < by + B);
    case (m_mode)
      0: return bar(h);
      1: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
      2: return inb ? 12'hF00 : 12'h00F;
      default: return inb ? 12'hF00 : bar(h);
    endcase
  endfunction

  task automatic drive_pix(input int h, input int v,
                           input bit hs, input bit vs, input bit von);
    ent_t e;
    logic [11:0] c;
    @(negedge clk);
    hc_i = 12'(h); vc_i = 12'(v);
    hs_i = hs; vs_i = vs; von_i = von;
    mode_r = 2'(nxt_mode); step_r = 4'(nxt_step);
    c = von ? exp_col(h, v) : 12'h000;
    e.due = cyc + 2;
    e.val = {1'b0, hs, vs, von, c};
    pq.push_back(e);
    if (v == V && h == 0) begin
      move(bx, m_dx, m_step, H - B);
      move(by, m_dy, m_step, V - B);
      m_mode = nxt_mode;
      m_step = nxt_step;
      m_fc = (m_fc + 1) % 65536;
    end
    e.due = cyc + 1;
    e.val = 16'(m_fc);
    fq.push_back(e);
  endtask

  task automatic tick();
    drive_pix(0, V, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic probe_box();
    if (bx > 0) drive_pix(bx - 1, by, 0, 0, 1);
    drive_pix(bx, by, 0, 0, 1);
    drive_pix(bx + B - 1, by + B - 1, 0, 0, 1);
    drive_pix(bx + B, by, 0, 0, 1);
    drive_pix(bx, by + B, 0, 0, 1);
    if (by > 0) drive_pix(bx, by - 1, 0, 0, 1);
  endtask

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_pix"},
        {1'b0, h_sync, v_sync, video_on, red, green, blue}, 16'h0);
    chk({nm, "_fc"}, frame_count, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    pq.delete();
    fq.delete();
    model_reset();
    hs_i = 0; vs_i = 0; von_i = 0; hc_i = '0; vc_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // monitor: compares each DUT output against the entry due now
  initial begin
    ent_t e;
    logic [15:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        act = {1'b0, h_sync, v_sync, video_on, red, green, blue};
        while (pq.size() > 0 && pq[0].due <= cyc) begin
          e = pq.pop_front();
          checks++;
          if (e.due != cyc || act !== e.val) begin
            errors++;
            $display("FAIL pix due=%0d cyc=%0d got=%h exp=%h",
                     e.due, cyc, act, e.val);
          end
        end
        while (fq.size() > 0 && fq[0].due <= cyc) begin
          e = fq.pop_front();
          checks++;
          if (e.due != cyc || frame_count !== e.val) begin
            errors++;
            $display("FAIL frame_count due=%0d got=%h exp=%h",
                     e.due, frame_count, e.val);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // sync latency: single h_sync pulse
    for (int i = 0; i < 16; i++)
      drive_pix(i, 10, i == 10, 0, 0);

    // colour bars, including masking by video_on
    drive_pix(85, 10, 0, 0, 1);
    drive_pix(85, 10, 0, 0, 0);
    for (int b = 0; b < 8; b++) begin
      drive_pix(b * 80, 10, 0, 0, 1);
      drive_pix(b * 80 + 79, 20, 0, 1, 1);
    end

    // mode change mid-frame only takes effect at the tick
    nxt_mode = 1;
    drive_pix(85, 10, 0, 0, 1);
    drive_pix(33, 2, 1, 0, 1);
    tick();
    drive_pix(85, 10, 0, 0, 1);
    drive_pix(33, 2, 0, 0, 1);
    drive_pix(33, 40, 0, 0, 1);
    drive_pix(2, 40, 0, 0, 1);

    // bounce: 41 ticks at step 15 reach x=600, then clamp, then back
    nxt_mode = 2;
    nxt_step = 15;
    tick();
    for (int i = 0; i < 40; i++) tick();
    probe_box();
    tick();
    probe_box();
    tick();
    probe_box();

    // step 0 holds the box still
    nxt_step = 0;
    tick();
    tick();
    probe_box();
    tick();
    probe_box();

    // bars with box overlay
    nxt_mode = 3;
    nxt_step = 7;
    tick();
    tick();
    probe_box();
    for (int b = 0; b < 8; b++) drive_pix(b * 80 + 5, 470, 0, 0, 1);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      nxt_mode = $urandom_range(0, 3);
      nxt_step = $urandom_range(0, 15);
      for (int i = 0; i < 150; i++)
        drive_pix($urandom_range(0, 799), $urandom_range(0, 524),
                  1'($urandom), 1'($urandom), 1'($urandom));
      probe_box();
      tick();
      repeat ($urandom_range(0, 5)) tick();
      probe_box();
    end

    // reset mid-frame during active video
    nxt_mode = 3;
    nxt_step = 9;
    drive_pix(100, 100, 0, 0, 1);
    drive_pix(101, 100, 1, 0, 1);
    do_reset();
    drive_pix(85, 10, 0, 0, 1);
    drive_pix(5, 5, 0, 0, 1);
    drive_pix(600, 300, 0, 0, 1);
    nxt_mode = 2;
    nxt_step = 0;
    tick();
    probe_box();

    // drain
    drive_pix(0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    if (pq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0",
               pq.size() + fq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
